cond_logic: RTL and testbench

- Conditional-execution stage of the single-cycle ARM control unit. Sits directly downstream of the instruction decoder.
- Consumes the decoder's FlagW, PCS, RegW and MemW outputs, plus the instruction condition field and the ALU flags.
- Holds the architectural NZCV flag register and evaluates Cond against it.
- Gates the datapath's PC-source, register-write and memory-write strobes so that a failed-condition instruction has no architectural effect.

---
 rtl/cond_logic_pkg.sv | 31 +++
 rtl/cond_logic_if.sv | 25 ++
 rtl/cond_logic_check.sv | 42 ++++
 rtl/cond_logic.sv | 64 ++++++
 tb/tb_cond_logic.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cond_logic_pkg.sv
// Shared types for the conditional-execution stage: condition codes,
// NZCV bit positions and the flag-register type.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/ALU-facing signal group of the conditional-execution stage.
// master: the control unit side driving decode results; slave: cond_logic.
interface cond_logic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );
endinterface

// File: rtl/cond_logic_check.sv
// Pure combinational condition evaluator (cond_e, flags_t) -> cond_ex.
// Kept standalone so a later pipelined hazard unit can reuse it.
module cond_check
  import cond_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Condition table; NV (reserved) never passes.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register plus condition gating of
// the PC-source, register-write and memory-write strobes.
// Optional macro COND_PERF_CNT_EN adds BranchCnt/SquashCnt counters.
module cond_logic
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  cond_logic_if.slave      bus
`ifdef COND_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] SquashCnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cond_logic: CNT_W must be at least 1");
  end

  flags_t flags_q;
  logic   cond_ex;

  cond_check u_check (
    .cond    (cond_e'(bus.Cond)),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS  & cond_ex;
  assign bus.RegWrite = bus.RegW & cond_ex;
  assign bus.MemWrite = bus.MemW & cond_ex;
  assign bus.Flags    = flags_q;

  // Flag register: NZ and CV fields load independently, only on a passing condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      if (bus.FlagW[1] && cond_ex) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0] && cond_ex) flags_q[1:0] <= bus.ALUFlags[1:0];
    end
  end

`ifdef COND_PERF_CNT_EN
  logic squash;
  assign squash = ~cond_ex & (bus.PCS | bus.RegW | bus.MemW);

  // Free-running wrap-around counters of taken branches and squashed instructions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BranchCnt <= '0;
      SquashCnt <= '0;
    end else begin
      if (bus.PCSrc) BranchCnt <= BranchCnt + 1'b1;
      if (squash)    SquashCnt <= SquashCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: stimulus pushes hand-derived expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_cond_logic;
  import cond_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cond_logic_if bif();

`ifdef COND_PERF_CNT_EN
  logic [3:0] branch_cnt, squash_cnt;
`endif

  cond_logic #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
`ifdef COND_PERF_CNT_EN
    ,
    .BranchCnt (branch_cnt),
    .SquashCnt (squash_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [7:0] exp;   // {CondEx, PCSrc, RegWrite, MemWrite, Flags}
    logic [3:0] bcnt;
    logic [3:0] scnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] exp_bc = '0;
  logic [3:0] exp_sc = '0;

  // Independent reference: base test on Cond[3:1], Cond[0] inverts it.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: return ~c[0];
    endcase
    return base ^ c[0];
  endfunction

  // Monitor: compare whenever an expectation is outstanding at the negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e = q.pop_front();
      got = {bif.CondEx, bif.PCSrc, bif.RegWrite, bif.MemWrite, bif.Flags};
      n_cmp++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got cex/pc/rw/mw/flags=%b want %b", e.name, got, e.exp);
      end
`ifdef COND_PERF_CNT_EN
      n_cmp++;
      if (branch_cnt !== e.bcnt || squash_cnt !== e.scnt) begin
        n_bad++;
        $display("FAIL %s_cnt: got br=%0d sq=%0d want br=%0d sq=%0d",
                 e.name, branch_cnt, squash_cnt, e.bcnt, e.scnt);
      end
`endif
    end
  end

  task automatic drive(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw);
    bif.Cond = c; bif.ALUFlags = alu; bif.FlagW = fw;
    bif.PCS = pcs; bif.RegW = regw; bif.MemW = memw;
  endtask

  task automatic push(input string nm, input logic pcs, input logic regw, input logic memw,
                      input logic cex, input logic [3:0] f);
    exp_t e;
    e.name = nm;
    e.exp  = {cex, pcs & cex, regw & cex, memw & cex, f};
    e.bcnt = exp_bc;
    e.scnt = exp_sc;
    q.push_back(e);
  endtask

  // One instruction per cycle; counters in the model advance on the edge that ends it.
  task automatic vec(input string nm, input logic [3:0] c, input logic [3:0] alu,
                     input logic [1:0] fw, input logic pcs, input logic regw,
                     input logic memw, input logic cex, input logic [3:0] f);
    @(posedge clk); #1;
    drive(c, alu, fw, pcs, regw, memw);
    push(nm, pcs, regw, memw, cex, f);
    if (reset) begin
      if (pcs & cex) exp_bc = exp_bc + 1'b1;
      if (!cex && (pcs | regw | memw)) exp_sc = exp_sc + 1'b1;
    end
  endtask

  initial begin
    logic [3:0] prev_f;
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset held low: flags zero, AL passes, EQ fails, flag writes ignored.
    vec("rst_al", 4'hE, 4'hF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    vec("rst_eq", 4'h0, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk); #1 reset = 1'b1;
    exp_bc = '0; exp_sc = '0;

    // SUBS sets Z, following BEQ is taken.
    vec("subs",    4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    vec("beq",     4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100);
    // ANDS under failing NE: no write, no flag update.
    vec("ands_ne", 4'h1, 4'b1000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100);
    vec("hold",    4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    // Flags=0010, then NZ-only update keeps C and does not load V.
    vec("set_c",   4'hE, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    vec("adds_nz", 4'hE, 4'b1001, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010);
    vec("ge",      4'hA, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
    vec("lt",      4'hB, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1010);
    // CV-only update keeps N,Z.
    vec("cv_only", 4'hE, 4'b0111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    vec("cv_chk",  4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
    prev_f = 4'b1011;

    // Full sweep of every Cond against every Flags value, all strobes requested.
    for (int f = 0; f < 16; f++) begin
      vec("sw_set", 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, prev_f);
      prev_f = 4'(f);
      for (int c = 0; c < 16; c++)
        vec($sformatf("sweep_c%0d_f%0d", c, f), 4'(c), ~4'(f), 2'b00, 1'b1, 1'b1, 1'b1,
            ref_cond(4'(c), 4'(f)), 4'(f));
    end
    // Reserved NV with MemW only: nothing written.
    vec("nv_memw", 4'hF, 4'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
    vec("nv_hold", 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);

    // Async reset mid-cycle: flags clear before the next edge, EQ now fails.
    @(posedge clk); #1;
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    exp_bc = '0; exp_sc = '0;
    push("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk); #1 reset = 1'b1;
    vec("post_rst", 4'hE, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    vec("post_chk", 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);

    // 17 taken branches, 3 squashed stores (NE fails with Z=1).
    for (int i = 0; i < 17; i++)
      vec("br", 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
    for (int i = 0; i < 3; i++)
      vec("str_sq", 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110);
    vec("cnt_end", 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    if (exp_bc != 4'd1 || exp_sc != 4'd3)
      $display("bench model counters off: br=%0d sq=%0d", exp_bc, exp_sc);

    // Async reset mid-sequence clears counters immediately.
    @(posedge clk); #1;
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    exp_bc = '0; exp_sc = '0;
    push("cnt_rst", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
